// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 round-robin dispatcher.
package demux_pkg;
    localparam int NCH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Cyclic priority search: first set bit of mask at or after ptr, wrapping mod 4.
module rr_pick
    import demux_pkg::*;
(
    input  logic [1:0] ptr,
    input  logic [3:0] mask,
    output logic [1:0] grant,
    output logic       any
);
    // rot[i] is the enable of channel ptr+i, so a fixed priority over rot is cyclic over mask
    logic [NCH-1:0] rot;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
            assign rot[gi] = mask[ptr + 2'(gi)];
        end
    endgenerate

    logic [1:0] offs;

    always_comb begin
        offs = 2'd0;
        if (rot[0])      offs = 2'd0;
        else if (rot[1]) offs = 2'd1;
        else if (rot[2]) offs = 2'd2;
        else if (rot[3]) offs = 2'd3;
        grant = ptr + offs;
        any   = |mask;
    end
endmodule

// File: rtl/demux_rr_dispatcher.sv
// Single-word holding stage that routes an input stream to one of four channels,
// either a fixed channel or round-robin over enabled channels.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_mode,
    input  logic [1:0]   cfg_sel,
    input  logic [3:0]   cfg_mask,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [3:0]   out_valid,
    output logic [W-1:0] out_data,
    input  logic [3:0]   out_ready,
    output logic [1:0]   out_sel,
    output logic         busy
);
    state_t       state_reg, state_next;
    logic [1:0]   ptr_reg;
    logic [1:0]   sel_reg;
    logic [W-1:0] data_reg;

    logic [1:0] rr_grant;
    logic       rr_any;
    logic       eligible;
    logic       rel;
    logic       accept;
    logic [1:0] target;

    rr_pick u_rr_pick (
        .ptr   (ptr_reg),
        .mask  (cfg_mask),
        .grant (rr_grant),
        .any   (rr_any)
    );

    assign eligible = (cfg_mode == MODE_FIXED) | rr_any;
    assign rel      = (state_reg == HOLD) & out_ready[sel_reg];
    // rst_n gates in_ready so nothing is accepted while the block is held in reset
    assign in_ready = rst_n & ((state_reg == IDLE) | rel) & eligible;
    assign accept   = in_valid & in_ready;
    assign target   = (cfg_mode == MODE_RR) ? rr_grant : cfg_sel;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = HOLD;
            HOLD:    if (rel && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd0;
            sel_reg   <= 2'd0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                sel_reg  <= target;
                data_reg <= in_data;
                // rotation order is fixed at accept time, independent of consumer readiness
                if (cfg_mode == MODE_RR) ptr_reg <= target + 2'd1;
            end
        end
    end

    always_comb begin
        out_valid = 4'b0000;
        if (state_reg == HOLD) out_valid[sel_reg] = 1'b1;
    end

    assign out_data = data_reg;
    assign out_sel  = sel_reg;
    assign busy     = (state_reg == HOLD);
endmodule

// File: doc/demux_rr_dispatcher.md
# demux_rr_dispatcher

Sequencing controller for the 1-to-4 demultiplexer path: accepts a word stream on one valid/ready input and dispatches each word to exactly one of four output channels. The target is either a fixed software-selected channel or strict round-robin rotation over enabled channels. It holds one word in a registered output stage and returns backpressure to the source. It sits between a single producer and four consumers that share one data bus, each with its own valid/ready pair.

## Interface

Parameters:
- W, 8, data width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cfg_mode  input  1  0 = fixed channel, 1 = round-robin.
- cfg_sel  input  2  target channel in fixed mode.
- cfg_mask  input  4  round-robin channel enables; bit k = channel k.
- in_valid  input  1  source has a word.
- in_data  input  W  source word.
- in_ready  output  1  block accepts a word this cycle (combinational).
- out_valid  output  4  one-hot; bit k = held word offered to channel k.
- out_data  output  W  held word, shared by all channels.
- out_ready  input  4  per-channel consumer ready.
- out_sel  output  2  channel of the held word.
- busy  output  1  a word is held.

## Operation

- State machine, 2 states:
  - IDLE: nothing is held.
  - HOLD: one word is held for out_sel.
- Accept rule: accept = in_valid & in_ready.
- Release rule: release = HOLD & out_ready[out_sel].
- Target selection, computed at accept from current config:
  - Fixed mode: the target is cfg_sel. cfg_mask is ignored.
  - Round-robin mode: the target is the first enabled channel at or after ptr, searching cyclically (ptr, ptr+1 … mod 4).
- Rotation pointer ptr (2 bits, internal):
  - On an accept in round-robin mode, ptr ← target+1 mod 4.
  - Unchanged in fixed mode.
  - No skipping based on out_ready. Order is decided at accept, never at release.
- in_ready = (IDLE | release) & eligible.
  - eligible = cfg_mode==0 | cfg_mask!=0.
  - Round-robin with an all-zero mask stalls the input indefinitely, with no error flag.
- Transitions:
  - IDLE→HOLD on accept.
  - HOLD→IDLE on release without accept.
  - HOLD→HOLD on release with accept: back-to-back, full throughput. Data, out_sel and out_valid update to the new word.
  - HOLD with no release: all held outputs are stable. in_data and config changes have no effect on the held word.
- out_valid = HOLD ? (1 << out_sel) : 0. Never more than one bit set.
- out_ready on channels other than out_sel is ignored.
- Config changes take effect only at the next accept. The held word keeps its target.

## Timing

- Reset values, applied asynchronously while rst_n=0:
  - state = IDLE, ptr = 0.
  - out_valid = 0, out_data = 0, out_sel = 0, busy = 0.
  - in_ready is forced to 0 while rst_n is low.
- Reset mid-transfer discards the held word. No output handshake completes for it.
- Latency: a word accepted at edge N appears on out_valid/out_data immediately after edge N. The earliest release is at edge N+1.
- Throughput: 1 word/cycle when the targeted consumers hold out_ready high.
- in_ready depends combinationally on out_ready, out_sel and the config inputs. There is no path from in_valid to in_ready.
- All state updates happen on the clk rising edge only.

## Structure

- Shared package demux_pkg:
  - NCH = 4.
  - State typedef {IDLE, HOLD}.
  - Mode constants MODE_FIXED = 0, MODE_RR = 1.
- Sub-module rr_pick: combinational cyclic priority search.
  - Inputs: ptr[1:0], mask[3:0].
  - Outputs: grant[1:0], any.
- The top level holds the FSM, the data/sel registers and ptr.

## Test plan

- Reset: assert rst_n=0 with in_valid=1 → out_valid=0, busy=0, in_ready=0. Release reset with cfg_mode=1, mask=4'b1111 → in_ready=1 at the next cycle.
- Round-robin full rate: mode=1, mask=4'b1111, all out_ready=1, stream 0x10…0x15 → out_valid sequence 0001, 0010, 0100, 1000, 0001, 0010 on consecutive cycles, carrying data 0x10…0x15, with no stall.
- Masked rotation: mask=4'b1010, ptr=0, send 0xA0, 0xA1, 0xA2 → delivered to channels 1, 3, 1. Then mask=0 → in_ready=0 with in_valid held high.
- Fixed mode with backpressure: mode=0, sel=2, out_ready[2]=0 for 5 cycles while out_ready[0]=1, send 0x55 → out_valid=0100 with data 0x55 held stable. in_ready=0 for those 5 cycles. Release when out_ready[2]=1, and ptr is unchanged.
- Config change while holding: hold 0x33 for channel 1 in round-robin, switch to mode=0/sel=3, then release → 0x33 exits on channel 1. The next word goes to channel 3.
- Reset mid-hold: hold 0x77, pulse rst_n low for 1 cycle → out_valid=0 immediately. 0x77 is never delivered, and the next word goes to channel 0.
